param_change_capture: RTL and testbench
=======================================

Name: param_change_capture

Overview:
Parametrised successor to the fixed-width sized-port input block. It samples a SIZE-wide input every clock and detects value changes, under a mode parameter. Each detected change is pushed into a DEPTH-entry show-ahead capture buffer with a read handshake. A saturating event counter and a sticky overflow flag run alongside the buffer. The block sits beside a monitored bus as a coverage/diagnostic tap.

Parameters:
SIZE, 4, width of monitored input and of each captured entry (>=1)
DEPTH, 4, capture buffer entries (power of 2, >=2)
CNT_W, 8, width of event counter (>=1)
MODE, 0, 0 = any bit change is an event; 1 = rise-only, event only when some bit goes 0->1

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
a  input  SIZE  monitored value
en  input  1  detection enable; when low, no events are generated
clear  input  1  synchronous clear of buffer, counter and overflow
rd_req  input  1  pop head entry when rd_valid is high
rd_data  output  SIZE  head entry (show-ahead)
rd_valid  output  1  buffer non-empty
full  output  1  occupancy == DEPTH
overflow  output  1  sticky: an event was dropped because the buffer was full
count  output  CNT_W  saturating count of all events, dropped ones included

Behaviour:
- Reset (reset_n low, asynchronous): a_q=0, occupancy=0, rd/wr pointers=0, count=0, overflow=0. Outputs: rd_valid=0, full=0, rd_data=0 (storage reset to 0).
- a_q <= a every cycle, regardless of en and clear. The first post-reset compare is therefore against 0.
- diff = a ^ a_q (MODE 0) or a & ~a_q (MODE 1).
- event = en & |diff & ~clear. Evaluated combinationally; its effects are visible the cycle after the edge on which it was sampled.
- Push: on event, write a to buffer[wr_ptr] if not full, or if full and a pop is accepted in the same cycle. Pointers wrap modulo DEPTH.
- Drop: on event with full and no pop, the value is discarded and overflow <= 1. overflow stays set until clear or reset.
- Pop: rd_req & rd_valid advances rd_ptr. rd_req while empty is ignored, with no error state.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. When empty, push+rd_req means push only, because rd_valid was 0.
- Occupancy uses $clog2(DEPTH)+1 bits.
- full = (occupancy == DEPTH); rd_valid = (occupancy != 0). Both derive from registered state, with no combinational path from inputs.
- count <= count+1 on every event, saturating at 2^CNT_W-1. It never wraps.
- clear (synchronous, highest priority below reset): occupancy=0, pointers=0, count=0, overflow=0. Any event or pop in the same cycle is discarded; a_q still updates.
- Reset mid-operation: all state returns to reset values immediately, with no completion of an in-flight push.
- Latency: a change on a at edge N sets rd_valid after edge N+1 and increments count at the same edge.

Test Plan:
- Reset/idle: hold reset_n=0, then release with a=0, en=1 for 5 cycles -> rd_valid=0, full=0, count=0, overflow=0.
- MODE 0 capture: a = 0 -> 1 -> 1 -> 3 with en=1 -> two entries queued. Pops yield rd_data=1, then 3. count=2, then rd_valid=0.
- MODE 1 filtering: a = 0 -> 5 -> 4 -> 6 -> two events (5, then 6, since 4->6 raises bit1). The 5->4 change is ignored and count=2.
- Overflow, DEPTH=4: 6 distinct changes, no reads -> full=1, overflow=1, count=6. Pops return the first 4 values in order.
- Simultaneous push/pop at full: with full=1, change a while asserting rd_req -> full stays 1 and overflow stays 0. The new value lands at the tail, and the old head is returned.
- Saturation and clear, CNT_W=2: 5 events -> count=3, held. Then assert clear together with an a change -> count=0, rd_valid=0, overflow=0, and that change is not captured.
- en gating: en=0 while a toggles for 4 cycles -> no captures, count unchanged. Set en=1 with a stable -> still no event, because a_q tracked a throughout.

Source files
------------

// File: rtl/param_change_capture.sv
// rtl/param_change_capture.sv - change-detect tap feeding a show-ahead capture buffer
//
// Samples a SIZE-wide bus every clock and flags value changes (any bit change,
// or rise-only when MODE=1). Each change is queued into a DEPTH-entry
// show-ahead buffer read with rd_req/rd_valid. A saturating event counter and
// a sticky overflow flag run alongside the buffer.
//
// Ports:
//   clock     in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   a         in   [SIZE]  monitored value
//   en        in   detection enable
//   clear     in   synchronous clear of buffer, counter and overflow
//   rd_req    in   pop head entry when rd_valid is high
//   rd_data   out  [SIZE]  head entry (show-ahead)
//   rd_valid  out  buffer non-empty
//   full      out  occupancy == DEPTH
//   overflow  out  sticky: an event was dropped while full
//   count     out  [CNT_W] saturating count of all events

module param_change_capture #(
    parameter int SIZE  = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int MODE  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SIZE-1:0]  a,
    input  logic             en,
    input  logic             clear,
    input  logic             rd_req,
    output logic [SIZE-1:0]  rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [SIZE-1:0]  a_q;
    logic [SIZE-1:0]  mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [SIZE-1:0]  diff;
    logic             evt;
    logic             pop;
    logic             push;
    logic             drop;

    generate
        if (MODE == 1) begin : g_rise
            assign diff = a & ~a_q;
        end else begin : g_any
            assign diff = a ^ a_q;
        end
    endgenerate

    // Status comes from registered state only, so no input reaches these outputs.
    assign full     = (occ_q == DEPTH_C);
    assign rd_valid = (occ_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign overflow = ovf_q;
    assign count    = cnt_q;

    assign evt  = en & (|diff) & ~clear;
    assign pop  = rd_req & rd_valid & ~clear;
    // A full buffer still accepts the new value when the head leaves in the same cycle.
    assign push = evt & (~full | pop);
    assign drop = evt & full & ~pop;

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // The previous-value register tracks the bus even while disabled or clearing,
            // so re-enabling never reports a stale change.
            a_q <= a;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= a;
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                occ_q <= occ_d;
                if (drop) begin
                    ovf_q <= 1'b1;
                end
                if (evt && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_param_change_capture.sv
// tb/tb_param_change_capture.sv - scoreboard bench for param_change_capture

module tb_param_change_capture;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] a;
    logic       en;
    logic       clear;
    logic       rd_req;

    logic [3:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       full0, full1;
    logic       overflow0, overflow1;
    logic [7:0] count0;
    logic [1:0] count1;

    always #5 clock = ~clock;

    param_change_capture #(.SIZE(4), .DEPTH(DEPTH), .CNT_W(8), .MODE(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .a(a), .en(en), .clear(clear), .rd_req(rd_req),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .overflow(overflow0), .count(count0)
    );

    param_change_capture #(.SIZE(4), .DEPTH(DEPTH), .CNT_W(2), .MODE(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .a(a), .en(en), .clear(clear), .rd_req(rd_req),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .overflow(overflow1), .count(count1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: captured values as plain queues, counts as integers.
    logic [3:0] mq0[$];
    logic [3:0] mq1[$];
    int         cnt0, cnt1;
    bit         ovf0, ovf1;
    logic [3:0] prev_a;
    bit         armed;

    // Scoreboard: values the DUT must return on accepted pops.
    logic [3:0] exp0[$];
    logic [3:0] exp1[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        exp0.delete(); exp1.delete();
        cnt0 = 0; cnt1 = 0;
        ovf0 = 0; ovf1 = 0;
        prev_a = 4'd0;
    endtask

    // Applies the inputs that were sampled at the edge just passed.
    task automatic step_model();
        bit changed, rose;
        changed = 0;
        rose    = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] != prev_a[i]) changed = 1;
            if (a[i] && !prev_a[i]) rose = 1;
        end
        if (clear) begin
            mq0.delete(); mq1.delete();
            cnt0 = 0; cnt1 = 0;
            ovf0 = 0; ovf1 = 0;
        end else begin
            if (rd_req && mq0.size() > 0) void'(mq0.pop_front());
            if (rd_req && mq1.size() > 0) void'(mq1.pop_front());
            if (en && changed) begin
                if (mq0.size() < DEPTH) mq0.push_back(a);
                else ovf0 = 1;
                if (cnt0 < 255) cnt0++;
            end
            if (en && rose) begin
                if (mq1.size() < DEPTH) mq1.push_back(a);
                else ovf1 = 1;
                if (cnt1 < 3) cnt1++;
            end
        end
        prev_a = a;
    endtask

    task automatic cyc(input logic [3:0] av, input logic e, input logic c, input logic r);
        @(posedge clock);
        #2;
        if (armed) step_model();
        a      = av;
        en     = e;
        clear  = c;
        rd_req = r;
        if (r && !c && mq0.size() > 0) exp0.push_back(mq0[0]);
        if (r && !c && mq1.size() > 0) exp1.push_back(mq1[0]);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        armed   = 0;
        a = 4'd0; en = 1'b0; clear = 1'b0; rd_req = 1'b0;
        model_reset();
        #1;
        chk("rst_valid0", int'(rd_valid0), 0);
        chk("rst_full0", int'(full0), 0);
        chk("rst_ovf0", int'(overflow0), 0);
        chk("rst_count0", int'(count0), 0);
        chk("rst_data0", int'(rd_data0), 0);
        chk("rst_count1", int'(count1), 0);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        armed   = 1;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on accepted reads.
    always @(negedge clock) begin
        if (reset_n && armed) begin
            chk("valid0", int'(rd_valid0), int'(mq0.size() != 0));
            chk("full0", int'(full0), int'(mq0.size() == DEPTH));
            chk("ovf0", int'(overflow0), int'(ovf0));
            chk("count0", int'(count0), cnt0);
            chk("valid1", int'(rd_valid1), int'(mq1.size() != 0));
            chk("full1", int'(full1), int'(mq1.size() == DEPTH));
            chk("ovf1", int'(overflow1), int'(ovf1));
            chk("count1", int'(count1), cnt1);
            if (rd_valid0 && rd_req && !clear) begin
                if (exp0.size() == 0) chk("pop0_unexpected", 1, 0);
                else chk("pop_data0", int'(rd_data0), int'(exp0.pop_front()));
            end
            if (rd_valid1 && rd_req && !clear) begin
                if (exp1.size() == 0) chk("pop1_unexpected", 1, 0);
                else chk("pop_data1", int'(rd_data1), int'(exp1.pop_front()));
            end
        end
    end

    initial begin
        logic [3:0] ra;
        reset_n = 1'b0;
        armed   = 0;
        a = 4'd0; en = 1'b0; clear = 1'b0; rd_req = 1'b0;
        model_reset();

        // Reset / idle
        do_reset();
        repeat (5) cyc(4'd0, 1'b1, 1'b0, 1'b0);
        chk("idle_valid0", int'(rd_valid0), 0);
        chk("idle_count0", int'(count0), 0);

        // Any-change capture: 0 -> 1 -> 1 -> 3, then two pops
        cyc(4'd1, 1'b1, 1'b0, 1'b0);
        cyc(4'd1, 1'b1, 1'b0, 1'b0);
        cyc(4'd3, 1'b1, 1'b0, 1'b0);
        cyc(4'd3, 1'b1, 1'b0, 1'b0);
        chk("cap_head0", int'(rd_data0), 1);
        cyc(4'd3, 1'b1, 1'b0, 1'b1);
        cyc(4'd3, 1'b1, 1'b0, 1'b1);
        cyc(4'd3, 1'b1, 1'b0, 1'b0);
        chk("cap_count0", int'(count0), 2);
        chk("cap_empty0", int'(rd_valid0), 0);

        // Rise-only filtering: 0 -> 5 -> 4 -> 6
        do_reset();
        cyc(4'd5, 1'b1, 1'b0, 1'b0);
        cyc(4'd4, 1'b1, 1'b0, 1'b0);
        cyc(4'd6, 1'b1, 1'b0, 1'b0);
        cyc(4'd6, 1'b1, 1'b0, 1'b0);
        chk("rise_count1", int'(count1), 2);
        chk("rise_head1", int'(rd_data1), 5);
        chk("any_count0", int'(count0), 3);

        // Overflow: six changes with no reads
        do_reset();
        for (int v = 1; v <= 6; v++) cyc(4'(v), 1'b1, 1'b0, 1'b0);
        cyc(4'd6, 1'b1, 1'b0, 1'b0);
        chk("ovf_full0", int'(full0), 1);
        chk("ovf_flag0", int'(overflow0), 1);
        chk("ovf_count0", int'(count0), 6);
        chk("sat_count1", int'(count1), 3);
        repeat (4) cyc(4'd6, 1'b1, 1'b0, 1'b1);
        cyc(4'd6, 1'b1, 1'b0, 1'b0);
        chk("ovf_drained0", int'(rd_valid0), 0);

        // Simultaneous push and pop while full
        do_reset();
        for (int v = 1; v <= 4; v++) cyc(4'(v), 1'b1, 1'b0, 1'b0);
        cyc(4'd4, 1'b1, 1'b0, 1'b0);
        cyc(4'd7, 1'b1, 1'b0, 1'b1);
        cyc(4'd7, 1'b1, 1'b0, 1'b0);
        chk("pp_full0", int'(full0), 1);
        chk("pp_ovf0", int'(overflow0), 0);
        chk("pp_head0", int'(rd_data0), 2);

        // Clear together with a change
        cyc(4'd8, 1'b1, 1'b1, 1'b0);
        cyc(4'd8, 1'b1, 1'b0, 1'b0);
        chk("clr_count0", int'(count0), 0);
        chk("clr_valid0", int'(rd_valid0), 0);
        chk("clr_count1", int'(count1), 0);

        // Enable gating: bus toggles while disabled, then re-enable with a stable bus
        cyc(4'd1, 1'b0, 1'b0, 1'b0);
        cyc(4'd2, 1'b0, 1'b0, 1'b0);
        cyc(4'd9, 1'b0, 1'b0, 1'b0);
        cyc(4'd15, 1'b0, 1'b0, 1'b0);
        cyc(4'd15, 1'b1, 1'b0, 1'b0);
        cyc(4'd15, 1'b1, 1'b0, 1'b0);
        chk("en_count0", int'(count0), 0);
        chk("en_valid0", int'(rd_valid0), 0);

        // Randomized traffic with an occasional mid-run reset
        ra = 4'd15;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) != 0) ra = 4'($urandom_range(0, 15));
            if (n == 700) do_reset();
            cyc(ra, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3,
                $urandom_range(0, 9) < 4);
        end
        cyc(ra, 1'b0, 1'b0, 1'b0);
        cyc(ra, 1'b0, 1'b0, 1'b0);
        chk("sb_empty0", exp0.size(), 0);
        chk("sb_empty1", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
